sub_bytes_engine: RTL and testbench

Iterative forward SubBytes unit for the AES-128 encrypt datapath. It is the encrypt-side counterpart of the decrypt inverse S-box. It accepts a 128-bit state over a valid/ready handshake and substitutes every byte through the FIPS-197 forward S-box, LANES bytes per cycle. It returns the substituted state over a second valid/ready handshake. It sits between AddRoundKey and ShiftRows in the encrypt round controller.

---
 rtl/sub_bytes_engine.sv | 139 +++++++++++++
 tb/tb_sub_bytes_engine.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sub_bytes_engine.sv
// Iterative forward SubBytes unit for the AES-128 encrypt round.
// Takes a 128-bit state over a valid/ready handshake, substitutes LANES bytes
// per cycle through the FIPS-197 forward S-box and returns the result over a
// second valid/ready handshake.
//   clk, reset          : rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready   : input handshake, in_state sampled on the accept edge
//   in_state[127:0]     : byte 0 = [127:120] ... byte 15 = [7:0]
//   out_valid/out_ready : output handshake, out_state held while out_valid
//   out_state[127:0]    : substituted state, same byte order
//   busy                : high while substituting or holding a result
module sub_bytes_engine #(
  parameter int unsigned LANES = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic         busy
);

  localparam int unsigned BEATS  = 16 / LANES;
  localparam int unsigned BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  // Only divisors of 16 give a whole number of beats per block.
  generate
    if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
      $error("sub_bytes_engine: LANES must be 1, 2, 4, 8 or 16");
    end
  endgenerate

  // FIPS-197 forward S-box, index 0x00 first.
  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SUB  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;
  logic [127:0]        work_q, work_d;
  logic                in_ready_q, in_ready_d;
  logic                out_valid_q, out_valid_d;
  logic                busy_q, busy_d;

  int unsigned         byte_idx;
  logic [6:0]          lsb;

  // Next-state, beat and working-register logic; outputs decoded from state_d
  // so they are registered alongside the state.
  always_comb begin
    state_d  = state_q;
    beat_d   = beat_q;
    work_d   = work_q;
    byte_idx = 0;
    lsb      = '0;

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          work_d  = in_state;
          beat_d  = '0;
          state_d = ST_SUB;
        end
      end
      ST_SUB: begin
        // Byte k lives at bits [8*(15-k) +: 8].
        for (int unsigned l = 0; l < LANES; l++) begin
          byte_idx = 32'(beat_q) * LANES + l;
          lsb      = 7'(8 * (15 - byte_idx));
          work_d[lsb +: 8] = SBOX[work_q[lsb +: 8]];
        end
        if (beat_q == BEAT_W'(BEATS - 1)) begin
          beat_d  = '0;
          state_d = ST_DONE;
        end else begin
          beat_d = beat_q + BEAT_W'(1);
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    in_ready_d  = (state_d == ST_IDLE);
    out_valid_d = (state_d == ST_DONE);
    busy_d      = (state_d != ST_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      beat_q      <= '0;
      work_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      work_q      <= work_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_state = work_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_sub_bytes_engine.sv
// Self-checking bench for sub_bytes_engine. Reference S-box is derived from
// GF(2^8) inversion plus the AES affine transform; the main instance uses
// LANES=4, two auxiliary instances cover LANES=1 and LANES=16.
module tb_sub_bytes_engine;

  localparam int unsigned BEATS = 4;

  logic         clk;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_state;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_state;
  logic         busy;

  // Auxiliary instances: index 0 -> LANES=1, index 1 -> LANES=16.
  logic         in_valid_a  [2];
  logic         in_ready_a  [2];
  logic [127:0] in_state_a  [2];
  logic         out_valid_a [2];
  logic         out_ready_a [2];
  logic [127:0] out_state_a [2];
  logic         busy_a      [2];

  int n_checks;
  int n_fail;

  logic [7:0] sbox_ref [256];
  logic [7:0] inv_ref  [256];

  sub_bytes_engine #(.LANES(4)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_state(in_state),
    .out_valid(out_valid), .out_ready(out_ready), .out_state(out_state),
    .busy(busy)
  );

  sub_bytes_engine #(.LANES(1)) dut_l1 (
    .clk(clk), .reset(reset),
    .in_valid(in_valid_a[0]), .in_ready(in_ready_a[0]), .in_state(in_state_a[0]),
    .out_valid(out_valid_a[0]), .out_ready(out_ready_a[0]), .out_state(out_state_a[0]),
    .busy(busy_a[0])
  );

  sub_bytes_engine #(.LANES(16)) dut_l16 (
    .clk(clk), .reset(reset),
    .in_valid(in_valid_a[1]), .in_ready(in_ready_a[1]), .in_state(in_state_a[1]),
    .out_valid(out_valid_a[1]), .out_ready(out_ready_a[1]), .out_state(out_state_a[1]),
    .busy(busy_a[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    a = a_in; b = b_in; p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = xtime(a);
      b = {1'b0, b[7:1]};
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
    logic [7:0] r;
    r = v;
    for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
    return r;
  endfunction

  // S-box from first principles: multiplicative inverse then affine map.
  task automatic build_ref();
    logic [7:0] inv, s;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) begin
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      end
      s = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
      sbox_ref[x] = s;
      inv_ref[s]  = 8'(x);
    end
  endtask

  function automatic logic [127:0] ref_sub(input logic [127:0] blk);
    logic [127:0] r;
    logic [7:0]   b;
    r = '0;
    for (int i = 0; i < 16; i++) begin
      b = 8'(blk >> (8 * (15 - i)));
      r = {r[119:0], sbox_ref[b]};
    end
    return r;
  endfunction

  function automatic logic [127:0] ref_inv(input logic [127:0] blk);
    logic [127:0] r;
    logic [7:0]   b;
    r = '0;
    for (int i = 0; i < 16; i++) begin
      b = 8'(blk >> (8 * (15 - i)));
      r = {r[119:0], inv_ref[b]};
    end
    return r;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One block through the main instance. Latency is counted with the accept
  // cycle as cycle 0; out_valid is expected first in cycle BEATS+1.
  task automatic run_block(input logic [127:0] blk, input logic [127:0] exp,
                           input int stall, input bit pulse);
    int t;
    int cyc;
    in_valid = 1'b1;
    in_state = blk;
    t = 0;
    while (!in_ready && t < 50) begin tick(); t++; end
    check_eq("accept_ready", 128'(in_ready), 128'(1));
    tick();
    in_valid = 1'b0;
    in_state = rand128();
    cyc = 1;
    while (!out_valid && cyc < 40) begin tick(); cyc++; end
    check_eq("out_valid_rise", 128'(out_valid), 128'(1));
    check_eq("latency", 128'(cyc), 128'(BEATS + 1));
    check_eq("out_state", out_state, exp);
    check_eq("busy_done", 128'(busy), 128'(1));
    for (int i = 0; i < stall; i++) begin
      if (pulse && i == 3) begin
        in_valid = 1'b1;
        in_state = rand128();
      end else begin
        in_valid = 1'b0;
      end
      tick();
      check_eq("hold_valid", 128'(out_valid), 128'(1));
      check_eq("hold_state", out_state, exp);
      check_eq("hold_in_ready", 128'(in_ready), 128'(0));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check_eq("post_xfer_valid", 128'(out_valid), 128'(0));
    check_eq("post_xfer_ready", 128'(in_ready), 128'(1));
    check_eq("post_xfer_busy", 128'(busy), 128'(0));
  endtask

  task automatic run_aux(input int k, input int beats, input logic [127:0] blk,
                         input logic [127:0] exp);
    int t;
    int cyc;
    in_valid_a[k]  = 1'b1;
    in_state_a[k]  = blk;
    out_ready_a[k] = 1'b1;
    t = 0;
    while (!in_ready_a[k] && t < 50) begin tick(); t++; end
    check_eq("aux_accept_ready", 128'(in_ready_a[k]), 128'(1));
    tick();
    in_valid_a[k] = 1'b0;
    in_state_a[k] = rand128();
    cyc = 1;
    while (!out_valid_a[k] && cyc < 40) begin tick(); cyc++; end
    check_eq("aux_out_valid_rise", 128'(out_valid_a[k]), 128'(1));
    check_eq("aux_latency", 128'(cyc), 128'(beats + 1));
    check_eq("aux_out_state", out_state_a[k], exp);
    tick();
    out_ready_a[k] = 1'b0;
    check_eq("aux_post_xfer_valid", 128'(out_valid_a[k]), 128'(0));
  endtask

  initial begin
    logic [127:0] blk, a_blk, b_blk;
    logic [127:0] got_q [2];
    int acc_cyc [2];
    int n_acc, n_out;
    bit acc, outx;
    logic [127:0] captured;

    n_checks  = 0;
    n_fail    = 0;
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_state  = '0;
    out_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      in_valid_a[k]  = 1'b0;
      in_state_a[k]  = '0;
      out_ready_a[k] = 1'b0;
    end
    build_ref();

    #1;
    check_eq("rst_in_ready", 128'(in_ready), 128'(1));
    check_eq("rst_out_valid", 128'(out_valid), 128'(0));
    check_eq("rst_out_state", out_state, 128'(0));
    check_eq("rst_busy", 128'(busy), 128'(0));
    tick(); tick();
    reset = 1'b0;
    tick();

    // FIPS-197 round-1 SubBytes vector.
    run_block(128'h193DE3BEA0F4E22B9AC68D2AE9F84808,
              128'hD42711AEE0BF98F1B8B45DE51E415230, 0, 1'b0);

    // Anchor bytes 00,01,53,52,FF followed by random filler.
    blk = {8'h00, 8'h01, 8'h53, 8'h52, 8'hFF, 88'(rand128())};
    run_block(blk, ref_sub(blk), 1, 1'b0);

    // Every byte value 00..FF across 16 blocks, plus inverse round-trip.
    for (int j = 0; j < 16; j++) begin
      blk = '0;
      for (int i = 0; i < 16; i++) blk = {blk[119:0], 8'(16 * j + i)};
      run_block(blk, ref_sub(blk), 0, 1'b0);
      check_eq("inv_roundtrip", ref_inv(out_state), blk);
    end

    // Backpressure with an ignored in_valid pulse during the stall.
    blk = rand128();
    run_block(blk, ref_sub(blk), 10, 1'b1);
    blk = rand128();
    run_block(blk, ref_sub(blk), 0, 1'b0);

    // Random blocks with random output stalls.
    for (int n = 0; n < 12; n++) begin
      blk = rand128();
      run_block(blk, ref_sub(blk), int'($urandom_range(0, 3)), 1'b0);
    end

    // Back-to-back blocks with out_ready tied high.
    a_blk = rand128();
    b_blk = rand128();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_state  = a_blk;
    n_acc = 0;
    n_out = 0;
    got_q[0] = '0; got_q[1] = '0;
    acc_cyc[0] = 0; acc_cyc[1] = 0;
    for (int c = 0; c < 60 && n_out < 2; c++) begin
      acc      = in_valid && in_ready;
      outx     = out_valid && out_ready;
      captured = out_state;
      tick();
      if (acc && n_acc < 2) begin
        acc_cyc[n_acc] = c;
        n_acc++;
        if (n_acc == 1) in_state = b_blk;
        else in_valid = 1'b0;
      end
      if (outx && n_out < 2) begin
        got_q[n_out] = captured;
        n_out++;
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check_eq("b2b_accepts", 128'(n_acc), 128'(2));
    check_eq("b2b_spacing", 128'(acc_cyc[1] - acc_cyc[0]), 128'(BEATS + 2));
    check_eq("b2b_first", got_q[0], ref_sub(a_blk));
    check_eq("b2b_second", got_q[1], ref_sub(b_blk));
    tick();

    // Reset while the beat counter sits at 2.
    blk = rand128();
    in_valid = 1'b1;
    in_state = blk;
    for (int t = 0; t < 50 && !in_ready; t++) tick();
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    check_eq("pre_reset_busy", 128'(busy), 128'(1));
    reset = 1'b1;
    #1;
    check_eq("midrst_out_valid", 128'(out_valid), 128'(0));
    check_eq("midrst_in_ready", 128'(in_ready), 128'(1));
    check_eq("midrst_out_state", out_state, 128'(0));
    check_eq("midrst_busy", 128'(busy), 128'(0));
    tick();
    reset = 1'b0;
    tick();
    blk = rand128();
    run_block(blk, ref_sub(blk), 0, 1'b0);

    // Other lane widths on the FIPS vector and a random block.
    run_aux(0, 16, 128'h193DE3BEA0F4E22B9AC68D2AE9F84808,
            128'hD42711AEE0BF98F1B8B45DE51E415230);
    run_aux(1, 1, 128'h193DE3BEA0F4E22B9AC68D2AE9F84808,
            128'hD42711AEE0BF98F1B8B45DE51E415230);
    blk = rand128();
    run_aux(0, 16, blk, ref_sub(blk));
    blk = rand128();
    run_aux(1, 1, blk, ref_sub(blk));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
